ov_init_seq: RTL and testbench

Power-up and register-configuration sequencer for the OV camera. Drives camera power-down and reset pins with timed holds. Walks an external register table of {reg,val} pairs and issues one write per entry to the SCCB byte-write engine over a req/done handshake. Retries NACKed writes, then raises work_done, which gates camera_ctrl capture enable.

---
 rtl/ov_init_seq.sv | 187 ++++++++++++++++++
 tb/tb_ov_init_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ov_init_seq.sv
// OV camera power-up and SCCB register-table sequencer.
// Drives pwdn/reset with timed holds, then walks a {reg,val} table with NACK retries.
module ov_init_seq #(
    parameter int unsigned ADDR_W       = 8,
    parameter logic [7:0]  DEV_ADDR     = 8'h42,
    parameter int unsigned PWDN_CYCLES  = 65536,
    parameter int unsigned RST_CYCLES   = 65536,
    parameter int unsigned WAIT_CYCLES  = 262144,
    parameter int unsigned GAP_CYCLES   = 1024,
    parameter int unsigned SWRST_CYCLES = 262144,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_req,
    output logic [7:0]        sccb_dev,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_val,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              ov_pwdn,
    output logic              ov_rst,
    output logic              work_done,
    output logic              error,
    output logic [31:0]       debug_out
);

    localparam logic [31:0] PWDN_LD  = 32'(PWDN_CYCLES - 1);
    localparam logic [31:0] RST_LD   = 32'(RST_CYCLES - 1);
    localparam logic [31:0] WAIT_LD  = 32'(WAIT_CYCLES - 1);
    localparam logic [31:0] GAP_LD   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] SWRST_LD = 32'(SWRST_CYCLES - 1);
    localparam logic [3:0]  MAX_R    = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_PWDN, S_RST, S_SETTLE, S_FETCH,
        S_LATCH, S_ISSUE, S_GAP, S_DONE, S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        reg_q, reg_d, val_q, val_d;
    logic [3:0]        retry_q, retry_d;
    logic              ok_q, ok_d;
    logic              req_q, req_d;
    logic              pwdn_q, pwdn_d, orst_q, orst_d;
    logic              wdone_q, wdone_d, err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            reg_q   <= '0;
            val_q   <= '0;
            retry_q <= '0;
            ok_q    <= 1'b0;
            req_q   <= 1'b0;
            pwdn_q  <= 1'b1;
            orst_q  <= 1'b0;
            wdone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
            retry_q <= retry_d;
            ok_q    <= ok_d;
            req_q   <= req_d;
            pwdn_q  <= pwdn_d;
            orst_q  <= orst_d;
            wdone_q <= wdone_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        val_d   = val_q;
        retry_d = retry_q;
        ok_d    = ok_q;
        req_d   = req_q;
        pwdn_d  = pwdn_q;
        orst_d  = orst_q;
        wdone_d = wdone_q;
        err_d   = err_q;
        unique case (state_q)
            S_PWDN: begin
                if (cnt_q == '0) begin
                    state_d = S_RST;
                    cnt_d   = RST_LD;
                    pwdn_d  = 1'b0;
                end else cnt_d = cnt_q - 32'd1;
            end
            S_RST: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                    cnt_d   = WAIT_LD;
                    orst_d  = 1'b1;
                end else cnt_d = cnt_q - 32'd1;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    retry_d = '0;
                end else cnt_d = cnt_q - 32'd1;
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                if (rom_data == 16'hFFFF) begin
                    state_d = S_DONE;
                    wdone_d = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    reg_d   = rom_data[15:8];
                    val_d   = rom_data[7:0];
                    req_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                // retry is cleared on success rather than in LATCH so re-fetches keep the count
                if (sccb_done) begin
                    req_d = 1'b0;
                    if (!sccb_nack) begin
                        ok_d    = 1'b1;
                        retry_d = '0;
                        if (addr_q == '1) begin
                            state_d = S_DONE;
                            wdone_d = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            cnt_d   = (reg_q == 8'h12 && val_q[7]) ? SWRST_LD : GAP_LD;
                        end
                    end else if (retry_q < MAX_R) begin
                        ok_d    = 1'b0;
                        retry_d = retry_q + 4'd1;
                        state_d = S_GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_FETCH;
                    if (ok_q) addr_d = addr_q + ADDR_W'(1);
                end else cnt_d = cnt_q - 32'd1;
            end
            default: ;
        endcase
        if (start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL)) begin
            state_d = S_PWDN;
            cnt_d   = PWDN_LD;
            pwdn_d  = 1'b1;
            orst_d  = 1'b0;
            req_d   = 1'b0;
            wdone_d = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_comb begin
        rom_addr  = addr_q;
        sccb_req  = req_q;
        sccb_dev  = DEV_ADDR;
        sccb_reg  = reg_q;
        sccb_val  = val_q;
        ov_pwdn   = pwdn_q;
        ov_rst    = orst_q;
        work_done = wdone_q;
        error     = err_q;
        debug_out = {state_q, retry_q, 8'h00, 16'(addr_q)};
    end

endmodule

// File: tb/tb_ov_init_seq.sv
// Bench for ov_init_seq: ROM and SCCB slave models, table-walk reference model, timed checks.
module tb_ov_init_seq;

    localparam int unsigned WAIT = 8;
    localparam int unsigned SWR  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data = 16'hFFFF;
    logic        sccb_req;
    logic [7:0]  sccb_dev, sccb_reg, sccb_val;
    logic        sccb_done = 1'b0;
    logic        sccb_nack = 1'b0;
    logic        ov_pwdn, ov_rst, work_done, error;
    logic [31:0] debug_out;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [15:0] rom [4];
    bit          plan[$];
    bit          nack_plan[$];
    logic [15:0] req_log[$];
    logic [15:0] exp_reqs[$];
    bit          ewd, eerr;
    int unsigned eaddr;
    int          base;
    int          stab_err = 0;
    logic        req_prev = 1'b0;
    logic [15:0] held = '0;
    int          sl_st = 0;
    int unsigned sl_lat = 0;

    ov_init_seq #(
        .ADDR_W(2), .DEV_ADDR(8'h42), .PWDN_CYCLES(4), .RST_CYCLES(4),
        .WAIT_CYCLES(WAIT), .GAP_CYCLES(2), .SWRST_CYCLES(SWR), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_req(sccb_req), .sccb_dev(sccb_dev), .sccb_reg(sccb_reg), .sccb_val(sccb_val),
        .sccb_done(sccb_done), .sccb_nack(sccb_nack), .ov_pwdn(ov_pwdn), .ov_rst(ov_rst),
        .work_done(work_done), .error(error), .debug_out(debug_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // slave: random latency, NACK outcomes taken in order from nack_plan
    always @(posedge clk) begin
        sccb_done <= 1'b0;
        sccb_nack <= 1'b0;
        if (rst) sl_st <= 0;
        else case (sl_st)
            0: if (sccb_req) begin sl_lat <= $urandom_range(0, 3); sl_st <= 1; end
            1: if (sl_lat == 0) begin
                   sccb_done <= 1'b1;
                   sccb_nack <= (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
                   sl_st <= 2;
               end else sl_lat <= sl_lat - 1;
            default: if (!sccb_req) sl_st <= 0;
        endcase
    end

    always @(posedge clk) begin
        req_prev <= sccb_req;
        held     <= {sccb_reg, sccb_val};
        if (sccb_req && !req_prev) req_log.push_back({sccb_reg, sccb_val});
        if (sccb_req && req_prev && {sccb_reg, sccb_val} != held) stab_err <= stab_err + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // walks the table: each entry retried up to 3 times after NACK, FFFF or last slot ends it
    task automatic model(input logic [15:0] t [4], input bit p[$], output logic [15:0] r[$],
                         output bit wd, output bit er, output int unsigned a);
        bit fin, acked;
        int unsigned tries;
        r = {};
        wd = 0; er = 0; a = 0; fin = 0;
        while (!fin) begin
            if (t[a] == 16'hFFFF) begin
                wd = 1; fin = 1;
            end else begin
                tries = 0; acked = 0;
                while (!acked && !fin) begin
                    r.push_back(t[a]);
                    if (p.size() > 0 && p.pop_front()) begin
                        if (tries == 3) begin er = 1; fin = 1; end
                        else tries++;
                    end else acked = 1;
                end
                if (acked) begin
                    if (a == 3) begin wd = 1; fin = 1; end
                    else a++;
                end
            end
        end
    endtask

    task automatic prep_run();
        model(rom, plan, exp_reqs, ewd, eerr, eaddr);
        nack_plan = plan;
        base = req_log.size();
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic end_check(input string tag);
        int n = 0;
        while (!(work_done || error) && n < 3000) begin @(negedge clk); n++; end
        chk({tag, "_timeout"}, n < 3000, 1);
        @(negedge clk);
        chk({tag, "_nreq"}, req_log.size() - base, exp_reqs.size());
        for (int i = 0; i < exp_reqs.size() && base + i < req_log.size(); i++)
            chk($sformatf("%s_req%0d", tag, i), req_log[base + i], exp_reqs[i]);
        chk({tag, "_work_done"}, work_done, ewd);
        chk({tag, "_error"}, error, eerr);
        chk({tag, "_rom_addr"}, rom_addr, eaddr);
        chk({tag, "_req_low"}, sccb_req, 0);
        chk({tag, "_debug"}, debug_out[23:0], 24'(eaddr));
    endtask

    function automatic logic [15:0] rnd_entry();
        logic [15:0] v = 16'($urandom);
        return (v == 16'hFFFF) ? 16'hFFFE : v;
    endfunction

    initial begin
        int n;
        rom = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        repeat (3) @(negedge clk);
        chk("rst_req", sccb_req, 0);
        chk("rst_pwdn", ov_pwdn, 1);
        chk("rst_ovrst", ov_rst, 0);
        chk("rst_wd_err", {work_done, error}, 0);
        chk("rst_regval", {rom_addr, sccb_reg, sccb_val}, 0);
        chk("rst_dev", sccb_dev, 8'h42);
        chk("rst_debug", debug_out[27:0], 0);
        rst = 1'b0;

        // timed power-up, soft-reset wait, two writes
        rom = '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF};
        plan = {};
        prep_run();
        pulse_start();
        n = 0; while (ov_pwdn && n < 100) begin n++; @(negedge clk); end
        chk("pwdn_hold", n, 4);
        n = 0; while (!ov_rst && n < 100) begin n++; @(negedge clk); end
        chk("rst_hold", n, 4);
        n = 0; while (!sccb_req && n < 100) begin n++; @(negedge clk); end
        chk("settle_to_req", n, WAIT + 2);
        chk("first_regval", {sccb_reg, sccb_val}, 16'h1280);
        n = 0; while (sccb_req && n < 100) begin n++; @(negedge clk); end
        n = 0; while (!sccb_req && n < 100) begin n++; @(negedge clk); end
        chk("swrst_gap", n, SWR + 2);
        end_check("t1");

        // two NACKs then ACK
        rom = '{16'h3A04, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        plan = {1, 1, 0};
        prep_run();
        pulse_start();
        end_check("t2");

        // retries exhausted
        plan = {1, 1, 1, 1};
        prep_run();
        pulse_start();
        end_check("t3");

        // restart from FAIL into an empty table
        rom = '{16'hFFFF, 16'h5555, 16'hFFFF, 16'hFFFF};
        plan = {};
        prep_run();
        pulse_start();
        chk("fail_restart_pwdn", ov_pwdn, 1);
        chk("fail_restart_err", error, 0);
        n = 0; while (ov_pwdn && n < 100) begin n++; @(negedge clk); end
        n = 0; while (!ov_rst && n < 100) begin n++; @(negedge clk); end
        n = 0; while (!work_done && n < 100) begin n++; @(negedge clk); end
        chk("empty_wd_time", n, WAIT + 2);
        end_check("t4");

        // start pulses inside ISSUE and GAP are ignored
        rom = '{rnd_entry(), rnd_entry(), rnd_entry(), 16'hFFFF};
        plan = {};
        prep_run();
        pulse_start();
        n = 0; while (!sccb_req && n < 200) begin n++; @(negedge clk); end
        chk("t5_req_seen", sccb_req, 1);
        pulse_start();
        n = 0; while (sccb_req && n < 200) begin n++; @(negedge clk); end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        end_check("t5");

        // reset during an active request
        pulse_start();
        n = 0; while (!sccb_req && n < 200) begin n++; @(negedge clk); end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", sccb_req, 0);
        chk("midrst_ovrst", ov_rst, 0);
        chk("midrst_pwdn", ov_pwdn, 1);
        chk("midrst_wd", work_done, 0);
        @(negedge clk) rst = 1'b0;
        nack_plan = {};

        // full table with no terminator: stops at last slot, then replays
        rom = '{rnd_entry(), rnd_entry(), rnd_entry(), rnd_entry()};
        plan = {};
        prep_run();
        pulse_start();
        end_check("t6a");
        prep_run();
        pulse_start();
        end_check("t6b");

        for (int k = 0; k < 8; k++) begin
            int unsigned len = $urandom_range(0, 4);
            for (int i = 0; i < 4; i++) rom[i] = (i < len) ? rnd_entry() : 16'hFFFF;
            plan = {};
            for (int i = 0; i < 8; i++) plan.push_back($urandom_range(0, 2) == 0);
            prep_run();
            pulse_start();
            end_check($sformatf("rnd%0d", k));
        end

        chk("reg_val_stable", stab_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
